// File: rtl/shor_period_engine.sv
// shor_period_engine: sequential multi-base Shor period finder and factor extractor.
// Flow per base: base mod N, gcd check, order search by shift-add modular multiplies,
// half-power, two GCDs, then cofactor by restoring divide. mu_cost tracks work done.
// Build option: define SHOR_LUCKY_GCD_EN to turn a nontrivial gcd(a, N) into an
// immediate factorisation (period reported as 0) instead of skipping that base.
module shor_period_engine #(
   parameter int WIDTH      = 32,
   parameter int NUM_BASES  = 4,
   parameter int MAX_PERIOD = 256,
   parameter int MU_WIDTH   = 24,
   localparam int IDX_W     = (NUM_BASES > 1) ? $clog2(NUM_BASES) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [WIDTH-1:0]           N,
   input  logic [NUM_BASES*WIDTH-1:0] bases_flat,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 status,
   output logic [WIDTH-1:0]           period,
   output logic [IDX_W-1:0]           base_idx,
   output logic [WIDTH-1:0]           factor1,
   output logic [WIDTH-1:0]           factor2,
   output logic [MU_WIDTH-1:0]        mu_cost
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [2:0] STAT_NONE      = 3'd0;
   localparam logic [2:0] STAT_FACTORED  = 3'd1;
   localparam logic [2:0] STAT_NO_FACTOR = 3'd2;
   localparam logic [2:0] STAT_BAD_INPUT = 3'd3;
   localparam logic [2:0] STAT_ABORTED   = 3'd4;
   localparam logic [MU_WIDTH-1:0] MU_ONE     = MU_WIDTH'(1);
   localparam logic [MU_WIDTH-1:0] MU_VERIFY  = MU_WIDTH'(4);
   localparam logic [MU_WIDTH-1:0] MU_MUL     = MU_WIDTH'(WIDTH);
   localparam logic [MU_WIDTH-1:0] MU_MUL_HIT = MU_WIDTH'(WIDTH + 8);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_AMOD, S_COPRIME, S_ORDER, S_HALF, S_HPOW,
      S_GCDM, S_GCDP, S_VERIFY, S_DIV2, S_FIN
   } state_t;

   // Saturating mu accumulation: never wraps past all-ones.
   function automatic logic [MU_WIDTH-1:0] mu_add(input logic [MU_WIDTH-1:0] m,
                                                  input logic [MU_WIDTH-1:0] inc);
      logic [MU_WIDTH:0] sum;
      sum = {1'b0, m} + {1'b0, inc};
      return sum[MU_WIDTH] ? {MU_WIDTH{1'b1}} : MU_WIDTH'(sum);
   endfunction

   // One double-and-add step of acc*2 + bit*a, reduced mod n (acc, a < n).
   function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc, input logic b,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] n);
      logic [WIDTH:0] t;
      t = {acc, 1'b0};
      t = (t >= {1'b0, n}) ? t - {1'b0, n} : t;
      t = t + (b ? {1'b0, a} : {(WIDTH+1){1'b0}});
      return WIDTH'((t >= {1'b0, n}) ? t - {1'b0, n} : t);
   endfunction

   state_t state_r, state_s;
   logic [WIDTH-1:0] n_r, n_s, a_r, a_s, x_r, x_s, y_r, y_s, h_r, h_s;
   logic [WIDTH-1:0] mplr_r, mplr_s, acc_r, acc_s, k_r, k_s, r_r, r_s, hcnt_r, hcnt_s;
   logic [WIDTH-1:0] g1_r, g1_s, f1_r, f1_s, q_r, q_s, rem_r, rem_s;
   logic [NUM_BASES*WIDTH-1:0] bases_r, bases_s;
   logic [IDX_W-1:0] idx_r, idx_s, base_idx_r, base_idx_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [WIDTH-1:0] period_r, period_s, factor1_r, factor1_s, factor2_r, factor2_s;
   logic [MU_WIDTH-1:0] mu_r, mu_s;
   logic [2:0] status_r, status_s;
   logic busy_r, busy_s, done_r, done_s, fail_s;

   logic [WIDTH-1:0] div_d_s, rem_nx_s, q_nx_s, mm_s, gmod_s;
   logic [WIDTH:0]   div_sh_s;
   logic             div_ge_s, last_base_s, g1_ok_s, g2_ok_s;

   assign div_d_s     = (state_r == S_AMOD) ? n_r : f1_r;
   assign div_sh_s    = {rem_r, q_r[WIDTH-1]};
   assign div_ge_s    = (div_sh_s >= {1'b0, div_d_s});
   assign rem_nx_s    = div_ge_s ? WIDTH'(div_sh_s - {1'b0, div_d_s}) : WIDTH'(div_sh_s);
   assign q_nx_s      = {q_r[WIDTH-2:0], div_ge_s};
   assign mm_s        = mm_step(acc_r, mplr_r[WIDTH-1], a_r, n_r);
   assign gmod_s      = (y_r != {WIDTH{1'b0}}) ? (x_r % y_r) : {WIDTH{1'b0}};
   assign last_base_s = (idx_r == IDX_W'(NUM_BASES - 1));
   assign g1_ok_s     = (g1_r > WIDTH'(1)) && (g1_r < n_r);
   assign g2_ok_s     = (x_r > WIDTH'(1)) && (x_r < n_r);

   // Next-state, datapath and registered-output computation for the whole engine.
   always_comb begin
      state_s = state_r;   n_s = n_r;       a_s = a_r;       x_s = x_r;       y_s = y_r;
      h_s = h_r;           mplr_s = mplr_r; acc_s = acc_r;   k_s = k_r;       r_s = r_r;
      hcnt_s = hcnt_r;     g1_s = g1_r;     f1_s = f1_r;     q_s = q_r;       rem_s = rem_r;
      bases_s = bases_r;   idx_s = idx_r;   cnt_s = cnt_r;   mu_s = mu_r;     status_s = status_r;
      period_s = period_r; factor1_s = factor1_r; factor2_s = factor2_r; base_idx_s = base_idx_r;
      fail_s = 1'b0;
      if (abort && (state_r != S_IDLE) && (state_r != S_FIN)) begin
         state_s = S_FIN; status_s = STAT_ABORTED; factor1_s = '0; factor2_s = '0;
      end else begin
         case (state_r)
            S_IDLE: if (start && !abort) begin
               n_s = N; bases_s = bases_flat; idx_s = '0; mu_s = '0; status_s = STAT_NONE;
               period_s = '0; factor1_s = '0; factor2_s = '0; base_idx_s = '0; state_s = S_LOAD;
            end else begin
               state_s = S_IDLE;
            end
            S_LOAD: if (n_r < WIDTH'(4)) begin
               status_s = STAT_BAD_INPUT; state_s = S_FIN;
            end else begin
               q_s = bases_r[int'(idx_r)*WIDTH +: WIDTH]; rem_s = '0; cnt_s = CNT_LAST; state_s = S_AMOD;
            end
            S_AMOD: begin
               q_s = q_nx_s; rem_s = rem_nx_s;
               if (cnt_r != '0) begin
                  cnt_s = cnt_r - CNT_W'(1);
               end else if (rem_nx_s < WIDTH'(2)) begin
                  fail_s = 1'b1;
               end else begin
                  a_s = rem_nx_s; x_s = n_r; y_s = rem_nx_s; state_s = S_COPRIME;
               end
            end
            S_COPRIME: if (y_r != '0) begin
               x_s = y_r; y_s = gmod_s; mu_s = mu_add(mu_r, MU_ONE);
            end else if (x_r == WIDTH'(1)) begin
               mplr_s = WIDTH'(1); acc_s = '0; k_s = '0; cnt_s = CNT_LAST; state_s = S_ORDER;
            end else begin
`ifdef SHOR_LUCKY_GCD_EN
               f1_s = x_r; r_s = '0; q_s = n_r; rem_s = '0; cnt_s = CNT_LAST; state_s = S_DIV2;
`else
               fail_s = 1'b1;
`endif
            end
            S_ORDER: if (cnt_r != '0) begin
               acc_s = mm_s; mplr_s = mplr_r << 1; cnt_s = cnt_r - CNT_W'(1);
            end else begin
               acc_s = '0; mplr_s = mm_s; cnt_s = CNT_LAST; k_s = k_r + WIDTH'(1);
               if (mm_s == WIDTH'(1)) begin
                  r_s = k_r + WIDTH'(1); mu_s = mu_add(mu_r, MU_MUL_HIT); state_s = S_HALF;
               end else if (k_r + WIDTH'(1) == WIDTH'(MAX_PERIOD)) begin
                  mu_s = mu_add(mu_r, MU_MUL); fail_s = 1'b1;
               end else begin
                  mu_s = mu_add(mu_r, MU_MUL);
               end
            end
            S_HALF: if (r_r[0]) begin
               fail_s = 1'b1;
            end else begin
               hcnt_s = r_r >> 1; mplr_s = WIDTH'(1); acc_s = '0; cnt_s = CNT_LAST; state_s = S_HPOW;
            end
            S_HPOW: if (cnt_r != '0) begin
               acc_s = mm_s; mplr_s = mplr_r << 1; cnt_s = cnt_r - CNT_W'(1);
            end else begin
               acc_s = '0; mplr_s = mm_s; cnt_s = CNT_LAST; h_s = mm_s;
               hcnt_s = hcnt_r - WIDTH'(1); mu_s = mu_add(mu_r, MU_MUL);
               if (hcnt_r == WIDTH'(1)) begin
                  x_s = n_r; y_s = mm_s - WIDTH'(1); state_s = S_GCDM;
               end else begin
                  state_s = S_HPOW;
               end
            end
            S_GCDM: if (y_r != '0) begin
               x_s = y_r; y_s = gmod_s; mu_s = mu_add(mu_r, MU_ONE);
            end else begin
               g1_s = x_r; x_s = n_r; state_s = S_GCDP;
               y_s = (h_r == n_r - WIDTH'(1)) ? '0 : h_r + WIDTH'(1);
            end
            S_GCDP: if (y_r != '0) begin
               x_s = y_r; y_s = gmod_s; mu_s = mu_add(mu_r, MU_ONE);
            end else begin
               state_s = S_VERIFY;
            end
            S_VERIFY: begin
               mu_s = mu_add(mu_r, MU_VERIFY);
               if (g1_ok_s || g2_ok_s) begin
                  f1_s = g1_ok_s ? g1_r : x_r; q_s = n_r; rem_s = '0; cnt_s = CNT_LAST; state_s = S_DIV2;
               end else begin
                  fail_s = 1'b1;
               end
            end
            S_DIV2: begin
               q_s = q_nx_s; rem_s = rem_nx_s;
               if (cnt_r != '0) begin
                  cnt_s = cnt_r - CNT_W'(1);
               end else begin
                  factor1_s = f1_r; factor2_s = q_nx_s; period_s = r_r; base_idx_s = idx_r;
                  status_s = STAT_FACTORED; state_s = S_FIN;
               end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
         endcase
      end
      idx_s    = fail_s ? idx_r + IDX_W'(1) : idx_s;
      status_s = (fail_s && last_base_s) ? STAT_NO_FACTOR : status_s;
      state_s  = fail_s ? (last_base_s ? S_FIN : S_LOAD) : state_s;
      busy_s   = (state_s != S_IDLE) && (state_s != S_FIN);
      done_s   = (state_s == S_FIN);
   end

   // Register bank: FSM state, datapath and all outputs; async clear to idle/zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE; n_r <= '0; a_r <= '0; x_r <= '0; y_r <= '0; h_r <= '0;
         mplr_r <= '0; acc_r <= '0; k_r <= '0; r_r <= '0; hcnt_r <= '0; g1_r <= '0;
         f1_r <= '0; q_r <= '0; rem_r <= '0; bases_r <= '0; idx_r <= '0; cnt_r <= '0;
         mu_r <= '0; status_r <= STAT_NONE; period_r <= '0; factor1_r <= '0;
         factor2_r <= '0; base_idx_r <= '0; busy_r <= 1'b0; done_r <= 1'b0;
      end else begin
         state_r <= state_s; n_r <= n_s; a_r <= a_s; x_r <= x_s; y_r <= y_s; h_r <= h_s;
         mplr_r <= mplr_s; acc_r <= acc_s; k_r <= k_s; r_r <= r_s; hcnt_r <= hcnt_s; g1_r <= g1_s;
         f1_r <= f1_s; q_r <= q_s; rem_r <= rem_s; bases_r <= bases_s; idx_r <= idx_s; cnt_r <= cnt_s;
         mu_r <= mu_s; status_r <= status_s; period_r <= period_s; factor1_r <= factor1_s;
         factor2_r <= factor2_s; base_idx_r <= base_idx_s; busy_r <= busy_s; done_r <= done_s;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign status   = status_r;
   assign period   = period_r;
   assign base_idx = base_idx_r;
   assign factor1  = factor1_r;
   assign factor2  = factor2_r;
   assign mu_cost  = mu_r;
endmodule

// File: tb/tb_shor_period_engine.sv
// Directed bench for shor_period_engine: hand-computed factorisations, base skipping,
// no-factor and bad-input paths, abort, start filtering and asynchronous reset.
module tb_shor_period_engine;
   localparam int W      = 32;
   localparam int BUDGET = 20000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start_a, abort_a, start_b, abort_b;
   logic [W-1:0] n_a, n_b;
   logic [4*W-1:0] bases_a, bases_b;
   logic         busy_a, done_a, busy_b, done_b;
   logic [2:0]   status_a, status_b;
   logic [W-1:0] period_a, factor1_a, factor2_a, period_b, factor1_b, factor2_b;
   logic [1:0]   base_idx_a, base_idx_b;
   logic [23:0]  mu_a, mu_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   shor_period_engine dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .N(n_a), .bases_flat(bases_a),
      .busy(busy_a), .done(done_a), .status(status_a), .period(period_a), .base_idx(base_idx_a),
      .factor1(factor1_a), .factor2(factor2_a), .mu_cost(mu_a)
   );

   shor_period_engine #(.MAX_PERIOD(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .N(n_b), .bases_flat(bases_b),
      .busy(busy_b), .done(done_b), .status(status_b), .period(period_b), .base_idx(base_idx_b),
      .factor1(factor1_b), .factor2(factor2_b), .mu_cost(mu_b)
   );

   function automatic logic [4*W-1:0] pack4(input logic [W-1:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch a run on dut_a; optionally pulse a second start while it is busy.
   task automatic run_a(input logic [W-1:0] n, input logic [4*W-1:0] b, input bit poke, output int c);
      @(negedge clk); n_a = n; bases_a = b; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      c = 0;
      while (done_a !== 1'b1 && c < BUDGET) begin
         @(negedge clk); c++;
         if (poke && c == 10) begin
            n_a = 32'd15; bases_a = pack4(32'd7, 32'd7, 32'd7, 32'd7); start_a = 1'b1;
         end else begin
            start_a = 1'b0;
         end
      end
      start_a = 1'b0;
   endtask

   task automatic expect_a(input string t, input logic [2:0] st, input logic [W-1:0] per,
                           input logic [W-1:0] f1, input logic [W-1:0] f2, input logic [1:0] bi,
                           input int c);
      chk({t, "_timeout"}, 64'(c < BUDGET), 64'd1);
      chk({t, "_done"}, 64'(done_a), 64'd1);
      chk({t, "_busy"}, 64'(busy_a), 64'd0);
      chk({t, "_status"}, 64'(status_a), 64'(st));
      chk({t, "_period"}, 64'(period_a), 64'(per));
      chk({t, "_factor1"}, 64'(factor1_a), 64'(f1));
      chk({t, "_factor2"}, 64'(factor2_a), 64'(f2));
      chk({t, "_base_idx"}, 64'(base_idx_a), 64'(bi));
      @(negedge clk);
      chk({t, "_pulse"}, 64'(done_a), 64'd0);
      chk({t, "_hold"}, 64'(status_a), 64'(st));
   endtask

   initial begin
      rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      n_a = '0; n_b = '0; bases_a = '0; bases_b = '0;
      #2;
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_status", 64'(status_a), 64'd0);
      chk("rst_factor1", 64'(factor1_a), 64'd0);
      chk("rst_mu", 64'(mu_a), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // 1: N=15, base 7 -> r=4, 3*5; mu = 2 gcd + 4*32+8 + 2*32 + 1 + 1 + 4 = 208
      run_a(32'd15, pack4(32'd7, 32'd7, 32'd7, 32'd7), 1'b0, cyc);
      chk("t1_mu", 64'(mu_a), 64'd208);
      expect_a("t1", 3'd1, 32'd4, 32'd3, 32'd5, 2'd0, cyc);

      // 2: N=21, base 4 has odd order 3, base 2 gives r=6, h=8 -> 7*3; stray start ignored
      run_a(32'd21, pack4(32'd4, 32'd2, 32'd5, 32'd5), 1'b1, cyc);
      expect_a("t2", 3'd1, 32'd6, 32'd7, 32'd3, 2'd1, cyc);

      // 3: N=15, all bases 14 -> h = N-1 every time -> NO_FACTOR
      run_a(32'd15, pack4(32'd14, 32'd14, 32'd14, 32'd14), 1'b0, cyc);
      expect_a("t3", 3'd2, 32'd0, 32'd0, 32'd0, 2'd0, cyc);

      // 4: N=15, base 6 shares factor 3 with N
      run_a(32'd15, pack4(32'd6, 32'd7, 32'd7, 32'd7), 1'b0, cyc);
`ifdef SHOR_LUCKY_GCD_EN
      expect_a("t4", 3'd1, 32'd0, 32'd3, 32'd5, 2'd0, cyc);
`else
      expect_a("t4", 3'd1, 32'd4, 32'd3, 32'd5, 2'd1, cyc);
`endif

      // 5a: MAX_PERIOD=4, N=21, base 2 has order 6 -> every base overflows
      @(negedge clk); n_b = 32'd21; bases_b = pack4(32'd2, 32'd2, 32'd2, 32'd2); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      cyc = 0;
      while (done_b !== 1'b1 && cyc < BUDGET) begin
         @(negedge clk); cyc++;
      end
      chk("t5_timeout", 64'(cyc < BUDGET), 64'd1);
      chk("t5_status", 64'(status_b), 64'd2);
      chk("t5_period", 64'(period_b), 64'd0);
      chk("t5_factor1", 64'(factor1_b), 64'd0);

      // 5b: N=3 is rejected, done two edges after the start edge
      run_a(32'd3, pack4(32'd7, 32'd7, 32'd7, 32'd7), 1'b0, cyc);
      chk("t5_bad_latency", 64'(cyc + 1 <= 3), 64'd1);
      expect_a("t5_bad", 3'd3, 32'd0, 32'd0, 32'd0, 2'd0, cyc);

      // start and abort together in IDLE: no run
      @(negedge clk); n_a = 32'd15; start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
      chk("idle_abort_busy", 64'(busy_a), 64'd0);
      repeat (3) @(negedge clk);
      chk("idle_abort_done", 64'(done_a), 64'd0);
      chk("idle_abort_status", 64'(status_a), 64'd3);

      // 6: abort during the second ORDER modmul of test 1 -> mu frozen at 2 + 32 = 34
      @(negedge clk); n_a = 32'd15; bases_a = pack4(32'd7, 32'd7, 32'd7, 32'd7); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (75) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk); abort_a = 1'b0;
      chk("t6_done", 64'(done_a), 64'd1);
      chk("t6_status", 64'(status_a), 64'd4);
      chk("t6_factor1", 64'(factor1_a), 64'd0);
      chk("t6_factor2", 64'(factor2_a), 64'd0);
      chk("t6_mu", 64'(mu_a), 64'd34);
      repeat (10) @(negedge clk);
      chk("t6_mu_frozen", 64'(mu_a), 64'd34);
      chk("t6_pulse", 64'(done_a), 64'd0);

      // mid-run asynchronous reset clears outputs without a clock edge
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (80) @(negedge clk);
      chk("rr_busy_before", 64'(busy_a), 64'd1);
      chk("rr_mu_before", 64'(mu_a), 64'd34);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_busy", 64'(busy_a), 64'd0);
      chk("rr_mu", 64'(mu_a), 64'd0);
      chk("rr_status", 64'(status_a), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      run_a(32'd15, pack4(32'd7, 32'd7, 32'd7, 32'd7), 1'b0, cyc);
      chk("t7_mu", 64'(mu_a), 64'd208);
      expect_a("t7", 3'd1, 32'd4, 32'd3, 32'd5, 2'd0, cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
